// File: rtl/vote_pkg.sv
// Shared definitions for the vote session controller: state encoding,
// parameter defaults and the timer width.
package vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_CLOSED  = 3'd4
  } vote_state_e;

  localparam int NUM_CAND_DEF       = 4;
  localparam int LOCKOUT_CYCLES_DEF = 50000000;   // 1 s at 50 MHz
  localparam int ARM_TIMEOUT_DEF    = 500000000;  // 10 s at 50 MHz
  localparam int CNT_W_DEF          = 10;

  // Wide enough for either timed phase at the default clock rate.
  localparam int TIMER_W = 32;

endpackage

// File: rtl/vote_session_controller_if.sv
// Bundle of officer/voter inputs and controller status outputs.
//
// Signalling: there is no back-pressure on this bus. arm and each
// valid_vote bit are single-cycle pulses sampled on the rising clock edge;
// the controller never stalls them, it either acts on or ignores a pulse
// depending on its state. vote_grant, spoiled and timed_out are single-cycle
// pulses the consumer must accept on the cycle they are high.
interface vote_session_controller_if
  import vote_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int CNT_W    = CNT_W_DEF
);
  logic                arm;
  logic                mode;
  logic [NUM_CAND-1:0] valid_vote;
  logic [NUM_CAND-1:0] vote_grant;
  logic                ballot_armed;
  logic                busy;
  logic                spoiled;
  logic                timed_out;
  logic [CNT_W-1:0]    ballots_cast;
  logic [2:0]          state;

  // Officer / voting-booth side.
  modport master (
    output arm, mode, valid_vote,
    input  vote_grant, ballot_armed, busy, spoiled, timed_out, ballots_cast, state
  );

  // Controller side.
  modport slave (
    input  arm, mode, valid_vote,
    output vote_grant, ballot_armed, busy, spoiled, timed_out, ballots_cast, state
  );
endinterface

// File: rtl/session_timer.sv
// Loadable down-counter with a zero flag. Shared by the arm-timeout and the
// post-commit lockout phases; it parks at zero rather than wrapping.
module session_timer
  import vote_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/vote_session_controller.sv
// Ballot session controller: arms one ballot per officer pulse, commits a
// single clean vote as a one-hot grant, rejects multi-candidate attempts,
// expires idle ballots and enforces a lockout after every commit.
module vote_session_controller
  import vote_pkg::*;
#(
  parameter int NUM_CAND       = NUM_CAND_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
  parameter int ARM_TIMEOUT    = ARM_TIMEOUT_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  vote_session_controller_if.slave bus
);
  localparam logic [TIMER_W-1:0] ARM_LOAD  = TIMER_W'(ARM_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  vote_state_e         state_q, state_d;
  logic [NUM_CAND-1:0] grant_q, grant_d;
  logic                spoil_q, spoil_d;
  logic                tout_q, tout_d;
  logic [CNT_W-1:0]    cast_q;
  logic                cast_inc;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0]  tmr_load_val;
  logic                vote_one, vote_multi;

  assign vote_one   = $onehot(bus.valid_vote);
  assign vote_multi = (bus.valid_vote != '0) && !vote_one;

  session_timer #(.W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; closing the polls (mode=1) overrides everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mode)     state_d = ST_CLOSED;
        else if (bus.arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.mode)          state_d = ST_CLOSED;
        else if (vote_one)     state_d = ST_COMMIT;
        else if (vote_multi)   state_d = ST_ARMED;
        else if (tmr_zero)     state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        state_d = bus.mode ? ST_CLOSED : ST_LOCKOUT;
      end
      ST_LOCKOUT: begin
        if (bus.mode)      state_d = ST_CLOSED;
        else if (tmr_zero) state_d = ST_IDLE;
      end
      ST_CLOSED: begin
        if (!bus.mode) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath decode: next values of the pulse registers and timer
  // control. A spoiled attempt holds the timer for that cycle.
  always_comb begin
    grant_d      = '0;
    spoil_d      = 1'b0;
    tout_d       = 1'b0;
    cast_inc     = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.mode && bus.arm) begin
          tmr_load     = 1'b1;
          tmr_load_val = ARM_LOAD;
        end
      end
      ST_ARMED: begin
        if (!bus.mode) begin
          if (vote_one) begin
            grant_d = bus.valid_vote;
          end else if (vote_multi) begin
            spoil_d = 1'b1;
          end else begin
            tmr_dec = 1'b1;
            tout_d  = tmr_zero;
          end
        end
      end
      ST_COMMIT: begin
        cast_inc     = 1'b1;
        tmr_load     = 1'b1;
        tmr_load_val = LOCK_LOAD;
      end
      ST_LOCKOUT: begin
        tmr_dec = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered pulses and the saturating ballot counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      spoil_q <= 1'b0;
      tout_q  <= 1'b0;
      cast_q  <= '0;
    end else begin
      grant_q <= grant_d;
      spoil_q <= spoil_d;
      tout_q  <= tout_d;
      if (cast_inc && (cast_q != {CNT_W{1'b1}})) begin
        cast_q <= cast_q + 1'b1;
      end
    end
  end

  assign bus.vote_grant   = grant_q;
  assign bus.spoiled      = spoil_q;
  assign bus.timed_out    = tout_q;
  assign bus.ballots_cast = cast_q;
  assign bus.ballot_armed = (state_q == ST_ARMED);
  assign bus.busy         = (state_q == ST_COMMIT) || (state_q == ST_LOCKOUT);
  assign bus.state        = state_q;
endmodule

// File: tb/tb_vote_session_controller.sv
// Bench for vote_session_controller with short timing constants
// (lockout 4 cycles, arm timeout 10 cycles) and a 2-bit ballot counter.
module tb_vote_session_controller;
  localparam int NC = 4;
  localparam int LK = 4;
  localparam int AT = 10;
  localparam int CW = 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_COMMIT  = 3'd2;
  localparam logic [2:0] S_LOCKOUT = 3'd3;
  localparam logic [2:0] S_CLOSED  = 3'd4;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [NC-1:0] exp_q[$];

  vote_session_controller_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  vote_session_controller #(
    .NUM_CAND(NC), .LOCKOUT_CYCLES(LK), .ARM_TIMEOUT(AT), .CNT_W(CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.arm        = 1'b0;
    bus.mode       = 1'b0;
    bus.valid_vote = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    exp_q.delete();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Advance one clock and sample 1 time unit after the edge; every grant
  // seen is matched against the expected queue.
  task automatic cycle();
    logic [NC-1:0] e;
    @(posedge clock);
    #1;
    if (bus.vote_grant !== '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got %b, expected no grant", bus.vote_grant);
      end else begin
        e = exp_q.pop_front();
        if (bus.vote_grant !== e) begin
          bad++;
          $display("FAIL grant_value: got %b, expected %b", bus.vote_grant, e);
        end
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.state === S_IDLE) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic commit_one(input logic [NC-1:0] v, output bit ok);
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    bus.valid_vote = v;
    exp_q.push_back(v);
    cycle();
    bus.valid_vote = '0;
    wait_idle(ok);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (bus.state !== S_IDLE || bus.vote_grant !== '0 || bus.ballots_cast !== '0) begin
      bad++;
      $display("FAIL reset_core: state=%0d grant=%b cast=%0d, expected 0/0000/0",
               bus.state, bus.vote_grant, bus.ballots_cast);
    end
    total++;
    if ({bus.ballot_armed, bus.busy, bus.spoiled, bus.timed_out} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: armed/busy/spoil/tout=%b, expected 0000",
               {bus.ballot_armed, bus.busy, bus.spoiled, bus.timed_out});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_vote();
    int busy_n;
    bit ok;
    apply_reset();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    total++;
    if (bus.state !== S_ARMED || bus.ballot_armed !== 1'b1) begin
      bad++;
      $display("FAIL armed_entry: state=%0d armed=%b, expected 1/1", bus.state, bus.ballot_armed);
    end
    cycle();
    cycle();
    bus.valid_vote = 4'b0100;
    exp_q.push_back(4'b0100);
    cycle();
    bus.valid_vote = '0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL grant_latency: %0d grants pending, expected 0", exp_q.size());
    end
    total++;
    if (bus.state !== S_COMMIT) begin
      bad++;
      $display("FAIL commit_state: got %0d, expected %0d", bus.state, S_COMMIT);
    end
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy !== 1'b1) break;
      busy_n++;
      cycle();
    end
    total++;
    if (busy_n != 5) begin
      bad++;
      $display("FAIL busy_len: got %0d cycles, expected 5", busy_n);
    end
    wait_idle(ok);
    total++;
    if (!ok || bus.ballots_cast !== 2'd1) begin
      bad++;
      $display("FAIL single_cast: idle=%0d cast=%0d, expected 1/1", ok, bus.ballots_cast);
    end
  endtask

  task automatic test_spoil();
    bit ok;
    apply_reset();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    bus.valid_vote = 4'b0011;
    cycle();
    bus.valid_vote = '0;
    total++;
    if (bus.spoiled !== 1'b1 || bus.state !== S_ARMED) begin
      bad++;
      $display("FAIL spoil_pulse: spoiled=%b state=%0d, expected 1/%0d", bus.spoiled, bus.state, S_ARMED);
    end
    bus.valid_vote = 4'b1000;
    exp_q.push_back(4'b1000);
    cycle();
    bus.valid_vote = '0;
    total++;
    if (bus.spoiled !== 1'b0 || bus.state !== S_COMMIT || exp_q.size() != 0) begin
      bad++;
      $display("FAIL spoil_then_vote: spoiled=%b state=%0d pending=%0d, expected 0/%0d/0",
               bus.spoiled, bus.state, exp_q.size(), S_COMMIT);
    end
    wait_idle(ok);
    total++;
    if (!ok || bus.ballots_cast !== 2'd1) begin
      bad++;
      $display("FAIL spoil_cast: idle=%0d cast=%0d, expected 1/1", ok, bus.ballots_cast);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.arm = (k == 5);  // re-arm while armed must not reload the timer
      cycle();
      if (bus.timed_out === 1'b1) begin
        n = k;
        break;
      end
    end
    bus.arm = 1'b0;
    total++;
    if (n != AT || bus.state !== S_IDLE) begin
      bad++;
      $display("FAIL timeout_at: got cycle %0d state %0d, expected %0d/%0d", n, bus.state, AT, S_IDLE);
    end
    cycle();
    total++;
    if (bus.timed_out !== 1'b0) begin
      bad++;
      $display("FAIL timeout_width: timed_out=%b, expected 0", bus.timed_out);
    end
    bus.valid_vote = 4'b0001;
    cycle();
    bus.valid_vote = '0;
    cycle();
    total++;
    if (bus.state !== S_IDLE || bus.spoiled !== 1'b0 || bus.ballots_cast !== 2'd0) begin
      bad++;
      $display("FAIL idle_vote: state=%0d spoiled=%b cast=%0d, expected 0/0/0",
               bus.state, bus.spoiled, bus.ballots_cast);
    end
  endtask

  task automatic test_timeout_priority();
    bit ok;
    apply_reset();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    repeat (AT - 1) cycle();
    total++;
    if (bus.state !== S_ARMED || bus.timed_out !== 1'b0) begin
      bad++;
      $display("FAIL last_armed: state=%0d tout=%b, expected %0d/0", bus.state, bus.timed_out, S_ARMED);
    end
    bus.valid_vote = 4'b0010;
    exp_q.push_back(4'b0010);
    cycle();
    bus.valid_vote = '0;
    total++;
    if (bus.state !== S_COMMIT || bus.timed_out !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL vote_beats_timeout: state=%0d tout=%b pending=%0d, expected %0d/0/0",
               bus.state, bus.timed_out, exp_q.size(), S_COMMIT);
    end
    wait_idle(ok);
  endtask

  task automatic test_lockout_ignore();
    apply_reset();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    bus.valid_vote = 4'b0001;
    exp_q.push_back(4'b0001);
    cycle();
    bus.valid_vote = '0;
    cycle();
    total++;
    if (bus.state !== S_LOCKOUT) begin
      bad++;
      $display("FAIL lockout_entry: got %0d, expected %0d", bus.state, S_LOCKOUT);
    end
    bus.arm = 1'b1;
    bus.valid_vote = 4'b0001;
    cycle();
    cycle();
    drive_idle();
    cycle();
    cycle();
    total++;
    if (bus.state !== S_IDLE || bus.ballots_cast !== 2'd1) begin
      bad++;
      $display("FAIL lockout_ignore: state=%0d cast=%0d, expected 0/1", bus.state, bus.ballots_cast);
    end
  endtask

  task automatic test_closed();
    apply_reset();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    bus.valid_vote = 4'b0100;
    exp_q.push_back(4'b0100);
    cycle();
    bus.valid_vote = '0;
    bus.mode = 1'b1;
    cycle();
    total++;
    if (bus.state !== S_CLOSED || bus.busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL commit_to_closed: state=%0d busy=%b pending=%0d, expected %0d/0/0",
               bus.state, bus.busy, exp_q.size(), S_CLOSED);
    end
    bus.arm = 1'b1;
    bus.valid_vote = 4'b0010;
    cycle();
    cycle();
    total++;
    if (bus.state !== S_CLOSED || bus.ballots_cast !== 2'd1) begin
      bad++;
      $display("FAIL closed_ignore: state=%0d cast=%0d, expected %0d/1", bus.state, bus.ballots_cast, S_CLOSED);
    end
    drive_idle();
    cycle();
    total++;
    if (bus.state !== S_IDLE) begin
      bad++;
      $display("FAIL reopen: got %0d, expected %0d", bus.state, S_IDLE);
    end
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    bus.mode = 1'b1;
    cycle();
    total++;
    if (bus.state !== S_CLOSED || bus.timed_out !== 1'b0 || bus.ballot_armed !== 1'b0) begin
      bad++;
      $display("FAIL armed_to_closed: state=%0d tout=%b armed=%b, expected %0d/0/0",
               bus.state, bus.timed_out, bus.ballot_armed, S_CLOSED);
    end
    drive_idle();
    cycle();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp_cast;
    logic [NC-1:0] v;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      v = NC'(1) << $urandom_range(0, NC - 1);
      commit_one(v, ok);
      exp_cast = (i > 3) ? 3 : i;
      total++;
      if (!ok || bus.ballots_cast !== CW'(exp_cast) || exp_q.size() != 0) begin
        bad++;
        $display("FAIL saturate_%0d: idle=%0d cast=%0d pending=%0d, expected 1/%0d/0",
                 i, ok, bus.ballots_cast, exp_q.size(), exp_cast);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    commit_one(4'b0010, ok);
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.state !== S_IDLE || bus.ballot_armed !== 1'b0 || bus.ballots_cast !== '0 ||
        bus.vote_grant !== '0 || bus.spoiled !== 1'b0 || bus.timed_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_armed: state=%0d armed=%b cast=%0d, expected 0/0/0",
               bus.state, bus.ballot_armed, bus.ballots_cast);
    end
    reset = 1'b0;
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
    total++;
    if (bus.state !== S_ARMED) begin
      bad++;
      $display("FAIL first_arm: got %0d, expected %0d", bus.state, S_ARMED);
    end
    bus.valid_vote = 4'b1000;
    exp_q.push_back(4'b1000);
    cycle();
    bus.valid_vote = '0;
    cycle();
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.state !== S_IDLE || bus.busy !== 1'b0 || bus.ballots_cast !== '0) begin
      bad++;
      $display("FAIL reset_mid_lockout: state=%0d busy=%b cast=%0d, expected 0/0/0",
               bus.state, bus.busy, bus.ballots_cast);
    end
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single_vote();
    test_spoil();
    test_timeout();
    test_timeout_priority();
    test_lockout_ignore();
    test_closed();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL grants_missing: %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
